// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and parity modes.
package uart_pkg;

  localparam int DATA_W      = 8;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, tick on terminal count.
module uart_baud_cnt #(
  parameter  int CLKS_PER_BIT = 16,
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  assign tick = en && (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Wrapping on tick makes every timed state start from zero without an explicit clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear || tick)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops a byte, sends start, 8 data LSB first, optional even parity, stop bits.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_t       state;
  logic [DATA_W-1:0] shift;
  logic              par;
  logic [2:0]        bit_idx;
  logic              stop_idx;
  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic              cnt_en;
  logic              last_stop;
  logic              pre_last;

  assign cnt_en    = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
  // tx_done is registered, so it is raised one cycle ahead of the final stop cycle.
  assign pre_last  = (cnt == CNT_W'(CLKS_PER_BIT - 2));

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clear (!cnt_en),
    .cnt   (cnt),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
      tx_done    <= 1'b0;
      shift      <= '0;
      par        <= 1'b0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      tx_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state      <= FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shift    <= fifo_data;
          par      <= even_parity(fifo_data);
          stop_idx <= 1'b0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (tick) begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              stop_idx <= 1'b0;
              if (PARITY_EN != PARITY_NONE) begin
                tx    <= par;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          if (last_stop && pre_last)
            tx_done <= 1'b1;
          if (tick) begin
            if (last_stop) begin
              if (!fifo_empty) begin
                state      <= FETCH;
                fifo_rd_en <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream consumer for the 8-bit synchronous FIFO. It pops one byte whenever the FIFO reports non-empty and serializes it onto a UART transmit line: one start bit, 8 data bits LSB first, optional even parity, and 1 or 2 stop bits. It connects directly to the FIFO's `read_en`, `data_out` and `empty` signals, giving the design a complete buffered byte-to-serial transmit path.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal range is ≥ 2.
- `PARITY_EN`, default 0: when 1, an even-parity bit is inserted after the data bits.
- `STOP_BITS`, default 1: number of stop bits. Legal values are 1 or 2.
- `clk`  input  1  single system clock; all logic is on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `fifo_empty`  input  1  FIFO `empty` flag.
- `fifo_data`  input  8  FIFO `data_out`; valid in the cycle after `fifo_rd_en` is high.
- `fifo_rd_en`  output  1  FIFO `read_en`; a one-cycle pop strobe.
- `tx`  output  1  serial line, idle high.
- `busy`  output  1  high from pop until the end of the last stop bit.
- `tx_done`  output  1  one-cycle pulse in the final cycle of the last stop bit.

## Operation
- FSM states and transitions:
  - IDLE → FETCH when `fifo_empty`=0.
  - FETCH → LOAD unconditionally.
  - LOAD → START.
  - START → DATA.
  - DATA → PARITY when `PARITY_EN`=1, otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP → FETCH if `fifo_empty`=0, else STOP → IDLE.
- FETCH: `fifo_rd_en`=1 for exactly this one cycle. It is a registered Moore output, never combinational from `fifo_empty`.
- LOAD: capture `fifo_data` into an 8-bit shift register and compute the parity bit as the XOR of the 8 bits.
- START: `tx`=0 for `CLKS_PER_BIT` cycles.
- DATA: `tx` = shift[0]. Shift right at each bit boundary; the bit index counts 0..7, giving 8 bit periods.
- PARITY: `tx` = even-parity bit for one bit period.
- STOP: `tx`=1 for `STOP_BITS` × `CLKS_PER_BIT` cycles.
- Bit-period counter width is $clog2(`CLKS_PER_BIT`). It counts 0..`CLKS_PER_BIT`-1; a terminal count advances the bit or state. It resets to 0 on every state entry.
- `fifo_rd_en` is never asserted while `fifo_empty`=1, so FIFO underflow is impossible by construction.
- `tx` is driven from a flop and never glitches.

## Timing
- Reset values, applied immediately and asynchronously: `tx`=1, `busy`=0, `fifo_rd_en`=0, `tx_done`=0, FSM in IDLE, counters 0.
- Latency from IDLE:
  - `fifo_empty` low sampled at edge k → FETCH in cycle k+1.
  - LOAD in cycle k+2.
  - `tx` falls in cycle k+3.
- Frame length from the FETCH cycle through the last stop cycle is 2 + `CLKS_PER_BIT`×(9 + `PARITY_EN` + `STOP_BITS`) cycles.
- Back-to-back frames: STOP exits directly to FETCH, leaving exactly 2 extra idle-high cycles (FETCH and LOAD) between stop and the next start.
- `busy` stays high continuously across back-to-back frames.
- `tx_done` pulses once per frame, coincident with the last STOP cycle.
- Reset mid-frame:
  - `tx` returns to 1 at once and the frame is aborted.
  - A byte already popped is discarded. The FIFO also resets on the same `rst`, so no resynchronization is needed.
- Changes on `fifo_empty` are ignored outside IDLE and the last STOP cycle.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP;
  - `DATA_W`=8;
  - the parity-mode constants.
- One natural sub-module, `uart_baud_cnt`. It is the bit-period counter with `clear` and `tick` outputs, parameterized by `CLKS_PER_BIT`, and is reused by a future UART receiver.
- Top level instantiates `uart_baud_cnt` and contains the FSM, shift register, parity and output flops.
- Integration: a wrapper connects `fifo_top.read_en`, `data_out` and `empty` to this block.

## Test plan
- Reset: assert `rst` with `fifo_empty`=0 → `tx`=1, `busy`=0, `fifo_rd_en`=0 throughout reset.
- Single byte, `CLKS_PER_BIT`=4, `PARITY_EN`=0, `fifo_data`=0xA5 →
  - one `fifo_rd_en` pulse;
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles;
  - `tx_done` pulses once in cycle 41 after FETCH.
- Parity, `PARITY_EN`=1, byte 0x07 → parity bit 1 follows the data. With byte 0x03, the parity bit is 0.
- Back-to-back, 3 bytes 0x00, 0xFF, 0x5A queued →
  - 3 `rd_en` pulses and 3 `tx_done` pulses;
  - `busy` continuously high;
  - exactly 2 idle-high cycles between each stop and the next start.
- Empty FIFO: `fifo_empty`=1 for 100 cycles → no `fifo_rd_en`, `tx`=1, `busy`=0.
- Mid-frame reset: assert `rst` during DATA bit 3 → `tx`=1 the same cycle. After release with `fifo_empty`=1, the block remains in IDLE.
